// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and multi-cycle sequencing controller for the five-stage pipeline.
// Optional HAZARD_PERF_EN builds the stall/flush performance counters; otherwise they read 0.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        branch_d,
  input  logic        pc_src_d,
  input  logic [4:0]  rs_e,
  input  logic [4:0]  rt_e,
  input  logic [4:0]  write_reg_e,
  input  logic        reg_write_e,
  input  logic        mem_to_reg_e,
  input  logic        syscall_e,
  input  logic        md_start_e,
  input  logic [4:0]  write_reg_m,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  input  logic [4:0]  write_reg_w,
  input  logic        reg_write_w,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        forward_a_d,
  output logic        forward_b_d,
  output logic        halt,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {RUN, MD_BUSY, SYS_DRAIN, HALT} state_t;

  localparam logic [7:0] MD_CNT_INIT  = 8'(MD_LATENCY - 1);
  localparam logic [7:0] SYS_CNT_INIT = 8'd2;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hold;
  logic       e_hits_d, m_hits_d, lw_stall, br_stall;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign e_hits_d = (write_reg_e != 5'd0) && (write_reg_e == rs_d || write_reg_e == rt_d);
  assign m_hits_d = (write_reg_m != 5'd0) && (write_reg_m == rs_d || write_reg_m == rt_d);
  assign lw_stall = mem_to_reg_e && reg_write_e && e_hits_d;
  assign br_stall = branch_d && ((reg_write_e && e_hits_d) || (mem_to_reg_m && m_hits_d));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (syscall_e) begin
          hold    = 1'b1;
          cnt_d   = SYS_CNT_INIT;
          state_d = SYS_DRAIN;
        end else if (md_start_e) begin
          hold    = 1'b1;
          cnt_d   = MD_CNT_INIT;
          state_d = MD_BUSY;
        end else if (lw_stall || br_stall) begin
          hold = 1'b1;
        end
      end
      MD_BUSY: begin
        hold  = 1'b1;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = RUN;
      end
      SYS_DRAIN: begin
        hold  = 1'b1;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = HALT;
      end
      HALT: hold = 1'b1;
    endcase
  end

  // While rst is high the pipeline registers are cleared and nothing is held.
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b1;
    flush_e     = 1'b1;
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    forward_a_d = 1'b0;
    forward_b_d = 1'b0;
    halt        = 1'b0;
    if (!rst) begin
      stall_f = hold;
      stall_d = hold;
      flush_e = hold;
      flush_d = pc_src_d && !hold;
      halt    = (state_q == HALT);
      // M result is newer than W, so it wins when both match.
      if (reg_write_m && write_reg_m != 5'd0 && write_reg_m == rs_e)      forward_a_e = 2'b10;
      else if (reg_write_w && write_reg_w != 5'd0 && write_reg_w == rs_e) forward_a_e = 2'b01;
      if (reg_write_m && write_reg_m != 5'd0 && write_reg_m == rt_e)      forward_b_e = 2'b10;
      else if (reg_write_w && write_reg_w != 5'd0 && write_reg_w == rt_e) forward_b_e = 2'b01;
      forward_a_d = reg_write_m && write_reg_m != 5'd0 && write_reg_m == rs_d;
      forward_b_d = reg_write_m && write_reg_m != 5'd0 && write_reg_m == rt_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q + 32'(stall_d);
    flush_count_d = flush_count_q + 32'(flush_d || flush_e);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule
